// File: rtl/rle_pkg.sv
// Shared widths, FSM states and symbol layout for the run-length encoder.
package rle_pkg;

    localparam int unsigned COEF_W    = 18;
    localparam int unsigned LEVEL_W   = 8;
    localparam int unsigned BLOCK_LEN = 8;
    localparam int unsigned RUN_W     = $clog2(BLOCK_LEN);
    localparam int unsigned QSHIFT    = 4;

    // Symmetric saturation range; the most negative code is never emitted
    localparam int LEVEL_MAX = (2 ** (LEVEL_W - 1)) - 1;
    localparam int LEVEL_MIN = -LEVEL_MAX;

    typedef enum logic [0:0] {
        S_ACCEPT = 1'b0,
        S_EOB    = 1'b1
    } rle_state_e;

    typedef struct packed {
        logic               eob;
        logic [RUN_W-1:0]   run;
        logic [LEVEL_W-1:0] level;
    } rle_sym_t;

    localparam rle_sym_t EOB_SYM = '{eob: 1'b1, run: '0, level: '0};

endpackage

// File: rtl/coef_quant.sv
// Combinational quantizer: divide by 2^QSHIFT truncating toward zero, then
// saturate symmetrically to +/-(2^(LEVEL_W-1)-1).
module coef_quant #(
    parameter int unsigned COEF_W  = 18,
    parameter int unsigned LEVEL_W = 8,
    parameter int unsigned QSHIFT  = 4
) (
    input  logic signed [COEF_W-1:0]  coef,
    output logic signed [LEVEL_W-1:0] level_c
);

    localparam logic signed [COEF_W-1:0] BIAS   = COEF_W'((1 << QSHIFT) - 1);
    localparam logic signed [COEF_W-1:0] SAT_HI = COEF_W'((2 ** (LEVEL_W - 1)) - 1);
    localparam logic signed [COEF_W-1:0] SAT_LO = -SAT_HI;

    logic signed [COEF_W-1:0] biased_c;
    logic signed [COEF_W-1:0] shifted_c;

    // Bias negatives so the arithmetic shift rounds toward zero, then clamp
    always_comb begin
        biased_c  = coef[COEF_W-1] ? (coef + BIAS) : coef;
        shifted_c = biased_c >>> QSHIFT;
        if (shifted_c > SAT_HI) begin
            level_c = LEVEL_W'(SAT_HI);
        end else if (shifted_c < SAT_LO) begin
            level_c = LEVEL_W'(SAT_LO);
        end else begin
            level_c = LEVEL_W'(shifted_c);
        end
    end

endmodule

// File: rtl/rle_encoder.sv
// Quantizes one serialized DCT block and emits (run, level) symbols plus EOB.
module rle_encoder
    import rle_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEF_W-1:0]  in_coef,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RUN_W-1:0]   out_run,
    output logic [LEVEL_W-1:0] out_level,
    output logic               out_eob,
    output logic               err_len
);

    rle_state_e         state_q, state_d;
    logic [RUN_W-1:0]   idx_q, idx_d;
    logic [RUN_W-1:0]   run_q, run_d;
    rle_sym_t           sym_q, sym_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;

    logic signed [LEVEL_W-1:0] q_c;
    logic               in_acc_c;
    logic               out_acc_c;
    logic               last_idx_c;
    logic               close_c;
    logic               nz_c;

    coef_quant #(
        .COEF_W  (COEF_W),
        .LEVEL_W (LEVEL_W),
        .QSHIFT  (QSHIFT)
    ) u_quant (
        .coef    (in_coef),
        .level_c (q_c)
    );

    // Handshake qualifiers and block-close detection
    always_comb begin
        in_acc_c   = in_valid && in_ready;
        out_acc_c  = vld_q && out_ready;
        last_idx_c = (idx_q == RUN_W'(BLOCK_LEN - 1));
        close_c    = in_last || last_idx_c;
        nz_c       = (q_c != '0);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ACCEPT;
            idx_q   <= '0;
            run_q   <= '0;
            sym_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            sym_q   <= sym_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // Next state: a block ending on a nonzero level still owes an EOB
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCEPT: if (in_acc_c && close_c && nz_c) state_d = S_EOB;
            S_EOB:    if (out_acc_c) state_d = S_ACCEPT;
            default:  state_d = S_ACCEPT;
        endcase
    end

    // Counters and output symbol register
    always_comb begin
        idx_d = idx_q;
        run_d = run_q;
        sym_d = sym_q;
        vld_d = vld_q;
        err_d = 1'b0;

        if (out_acc_c) begin
            vld_d = 1'b0;
        end

        if (state_q == S_EOB && out_acc_c) begin
            vld_d = 1'b1;
            sym_d = EOB_SYM;
        end

        if (in_acc_c) begin
            err_d = in_last != last_idx_c;
            idx_d = close_c ? '0 : idx_q + RUN_W'(1);
            if (nz_c) begin
                vld_d = 1'b1;
                sym_d = '{eob: 1'b0, run: run_q, level: q_c};
                run_d = '0;
            end else if (close_c) begin
                vld_d = 1'b1;
                sym_d = EOB_SYM;
                run_d = '0;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    // Input ready and output port mapping
    always_comb begin
        in_ready  = 1'b0;
        if (reset && state_q == S_ACCEPT) begin
            in_ready = !vld_q || out_ready;
        end
        out_valid = vld_q;
        out_run   = sym_q.run;
        out_level = sym_q.level;
        out_eob   = sym_q.eob;
        err_len   = err_q;
    end

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder with a queue-based reference model.
module tb_rle_encoder;
    import rle_pkg::*;

    localparam int unsigned SYM_W = 2 + RUN_W + LEVEL_W;
    typedef logic [SYM_W-1:0] sym_t;   // {err, eob, run, level}

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [COEF_W-1:0]  in_coef;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [RUN_W-1:0]   out_run;
    logic [LEVEL_W-1:0] out_level;
    logic               out_eob;
    logic               err_len;

    int   total = 0;
    int   bad   = 0;
    int   rdy_mode = 1;          // 1: forced value, 2: random
    logic rdy_force = 1'b1;
    logic rdy_rnd   = 1'b1;
    sym_t got_q[$];
    sym_t exp_q[$];
    int   err_cnt = 0;
    bit   err_pend = 1'b0;

    always #5 clk = ~clk;

    assign out_ready = (rdy_mode == 2) ? rdy_rnd : rdy_force;

    always @(posedge clk) begin
        #1;
        rdy_rnd = ($urandom_range(0, 3) != 0);
    end

    rle_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_run   (out_run),
        .out_level (out_level),
        .out_eob   (out_eob),
        .err_len   (err_len)
    );

    // Collect accepted symbols, tagging each with an err_len seen at its load
    always @(negedge clk) begin
        if (!reset) begin
            err_pend = 1'b0;
        end else begin
            if (err_len) begin
                err_pend = 1'b1;
                err_cnt++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back({err_pend, out_eob, out_run, out_level});
                err_pend = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: quantize by true division, then run-length code
    task automatic model_block(input int c[8], input int n, input bit has_last);
        int run = 0;
        bit err = has_last ? (n != int'(BLOCK_LEN)) : 1'b1;
        for (int i = 0; i < n; i++) begin
            int q = c[i] / (1 << QSHIFT);
            bit cl = (i == n - 1);
            if (q > LEVEL_MAX) q = LEVEL_MAX;
            if (q < LEVEL_MIN) q = LEVEL_MIN;
            if (q != 0) begin
                exp_q.push_back({cl && err, 1'b0, RUN_W'(run), LEVEL_W'(q)});
                run = 0;
                if (cl) exp_q.push_back({1'b0, 1'b1, RUN_W'(0), LEVEL_W'(0)});
            end else if (cl) begin
                exp_q.push_back({err, 1'b1, RUN_W'(0), LEVEL_W'(0)});
            end else begin
                run++;
            end
        end
    endtask

    // Present one coefficient and hold it until accepted (bounded)
    task automatic send_coef(input int c, input bit last);
        int budget = 200;
        in_valid = 1'b1;
        in_coef  = COEF_W'(c);
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            budget--;
            if (budget == 0) begin
                total++;
                bad++;
                $display("FAIL accept_timeout coef=%0d in_ready=%b required=1", c, in_ready);
                break;
            end
        end
        in_valid = 1'b0;
        in_coef  = '0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input int c[8], input int n, input bit has_last, input bit gaps);
        model_block(c, n, has_last);
        for (int i = 0; i < n; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            send_coef(c[i], has_last && (i == n - 1));
        end
    endtask

    task automatic drain(input int gb);
        in_valid  = 1'b0;
        rdy_mode  = 1;
        rdy_force = 1'b1;
        for (int k = 0; k < 60 && (got_q.size() - gb) < exp_q.size(); k++) idle(1);
        idle(4);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        in_coef = '0;
        in_last = 1'b0;
        #2;
        total++;
        if ({out_valid, out_eob, err_len, in_ready, out_run, out_level} !== '0) begin
            bad++;
            $display("FAIL reset_state got v=%b eob=%b err=%b rdy=%b run=%0d lvl=%0d required all 0",
                     out_valid, out_eob, err_len, in_ready, out_run, out_level);
        end
        idle(3);
        reset = 1'b1;
        idle(1);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_zeros();
        int blk[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int gb = got_q.size();
        exp_q.delete();
        model_block(blk, 8, 1'b1);
        for (int i = 0; i < 8; i++) send_coef(blk[i], i == 7);
        total++;
        if ({out_valid, out_eob, err_len} !== 3'b110 || out_run !== '0 || out_level !== '0) begin
            bad++;
            $display("FAIL zeros_latency got v=%b eob=%b err=%b run=%0d lvl=%0d required v=1 eob=1 err=0",
                     out_valid, out_eob, err_len, out_run, out_level);
        end
        drain(gb);
        total++;
        if (got_q.size() - gb != exp_q.size()) begin
            bad++;
            $display("FAIL zeros_count got=%0d required=%0d", got_q.size() - gb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[gb + i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL zeros_sym[%0d] got=%h required=%h", i, got_q[gb + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_directed();
        int b1[8] = '{160, 0, 0, -48, 0, 0, 0, 0};
        int b2[8] = '{160, -1, 15, -48, 15, 0, -15, -1};
        int b3[8] = '{0, 0, 0, 0, 0, 0, 0, 32};
        int b4[8] = '{16, 0, 0, 0, 0, 0, 0, 0};
        int gb = got_q.size();
        exp_q.delete();
        send_block(b1, 8, 1'b1, 1'b0);
        send_block(b2, 8, 1'b1, 1'b0);
        model_block(b3, 8, 1'b1);
        for (int i = 0; i < 8; i++) send_coef(b3[i], i == 7);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_run !== RUN_W'(7) || out_level !== LEVEL_W'(2)) begin
            bad++;
            $display("FAIL eob_pending got rdy=%b v=%b run=%0d lvl=%0d required rdy=0 v=1 run=7 lvl=2",
                     in_ready, out_valid, out_run, out_level);
        end
        in_valid = 1'b1;
        in_coef  = COEF_W'(b4[0]);
        idle(1);
        total++;
        if (in_ready !== 1'b1 || out_eob !== 1'b1) begin
            bad++;
            $display("FAIL eob_then_ready got rdy=%b eob=%b required rdy=1 eob=1", in_ready, out_eob);
        end
        model_block(b4, 8, 1'b1);
        for (int i = 0; i < 8; i++) send_coef(b4[i], i == 7);
        drain(gb);
        total++;
        if (got_q.size() - gb != exp_q.size()) begin
            bad++;
            $display("FAIL directed_count got=%0d required=%0d", got_q.size() - gb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[gb + i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL directed_sym[%0d] got=%h required=%h", i, got_q[gb + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int b1[8] = '{131071, -131072, 0, 2047, -2047, -2032, 2032, 0};
        int gb = got_q.size();
        exp_q.delete();
        rdy_mode = 2;
        send_block(b1, 8, 1'b1, 1'b1);
        drain(gb);
        total++;
        if (got_q.size() - gb != exp_q.size()) begin
            bad++;
            $display("FAIL sat_count got=%0d required=%0d", got_q.size() - gb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[gb + i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL sat_sym[%0d] got=%h required=%h", i, got_q[gb + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int b1[8] = '{160, 0, 0, -48, 0, 0, 0, 0};
        int gb = got_q.size();
        logic [RUN_W+LEVEL_W+1:0] snap;
        exp_q.delete();
        model_block(b1, 8, 1'b1);
        rdy_mode = 1;
        rdy_force = 1'b1;
        send_coef(b1[0], 1'b0);
        rdy_force = 1'b0;
        snap = {out_valid, out_eob, out_run, out_level};
        in_valid = 1'b1;
        in_coef  = COEF_W'(b1[1]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({out_valid, out_eob, out_run, out_level} !== snap || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d got=%h rdy=%b required=%h rdy=0",
                         k, {out_valid, out_eob, out_run, out_level}, in_ready, snap);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rdy_force = 1'b1;
        for (int i = 1; i < 8; i++) send_coef(b1[i], i == 7);
        drain(gb);
        total++;
        if (got_q.size() - gb != exp_q.size()) begin
            bad++;
            $display("FAIL bp_count got=%0d required=%0d", got_q.size() - gb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[gb + i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL bp_sym[%0d] got=%h required=%h", i, got_q[gb + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_len_err();
        int ba[8] = '{0, 0, 48, 0, 16, 0, 0, 0};
        int bb[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int bc[8] = '{16, 0, 0, 0, 0, 0, 0, 0};
        int bd[8] = '{0, 33, 0, 0, -70, 0, 0, 500};
        int gb = got_q.size();
        int eb = err_cnt;
        exp_q.delete();
        send_block(ba, 5, 1'b1, 1'b0);
        send_block(bb, 5, 1'b1, 1'b0);
        send_block(bc, 8, 1'b0, 1'b0);
        send_block(bd, 8, 1'b1, 1'b0);
        drain(gb);
        total++;
        if (err_cnt - eb != 3) begin
            bad++;
            $display("FAIL err_pulses got=%0d required=3", err_cnt - eb);
        end
        total++;
        if (got_q.size() - gb != exp_q.size()) begin
            bad++;
            $display("FAIL lenerr_count got=%0d required=%0d", got_q.size() - gb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[gb + i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL lenerr_sym[%0d] got=%h required=%h", i, got_q[gb + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int b1[8] = '{0, -160, 0, 0, 64, 0, 0, 16};
        int gb;
        rdy_mode = 1;
        rdy_force = 1'b0;
        send_coef(0, 1'b0);
        send_coef(160, 1'b0);
        in_valid = 1'b1;
        in_coef  = COEF_W'(0);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({out_valid, out_eob, err_len, in_ready, out_run, out_level} !== '0) begin
            bad++;
            $display("FAIL reset_mid got v=%b eob=%b err=%b rdy=%b run=%0d lvl=%0d required all 0",
                     out_valid, out_eob, err_len, in_ready, out_run, out_level);
        end
        in_valid = 1'b0;
        rdy_force = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(1);
        gb = got_q.size();
        exp_q.delete();
        send_block(b1, 8, 1'b1, 1'b0);
        drain(gb);
        total++;
        if (got_q.size() - gb != exp_q.size()) begin
            bad++;
            $display("FAIL rstmid_count got=%0d required=%0d", got_q.size() - gb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[gb + i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rstmid_sym[%0d] got=%h required=%h", i, got_q[gb + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int gb = got_q.size();
        int blk[8];
        exp_q.delete();
        rdy_mode = 2;
        for (int b = 0; b < 40; b++) begin
            bit has_last = ($urandom_range(0, 4) != 0);
            int n = has_last ? int'($urandom_range(1, 8)) : 8;
            for (int i = 0; i < 8; i++) begin
                int r = $urandom_range(0, 9);
                int mag;
                if (r < 4) mag = 0;
                else if (r < 6) mag = $urandom_range(0, 15);
                else if (r < 9) mag = $urandom_range(16, 4000);
                else mag = $urandom_range(0, 131072);
                blk[i] = $urandom_range(0, 1) ? -mag : ((mag > 131071) ? 131071 : mag);
            end
            send_block(blk, n, has_last, 1'b1);
        end
        drain(gb);
        total++;
        if (got_q.size() - gb != exp_q.size()) begin
            bad++;
            $display("FAIL random_count got=%0d required=%0d", got_q.size() - gb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[gb + i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL random_sym[%0d] got=%h required=%h", i, got_q[gb + i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_directed();
        test_saturation();
        test_backpressure();
        test_len_err();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rle_encoder.md
Name: rle_encoder

Overview:
- Downstream stage of the DA-DCT coefficient units (dct_z0..dct_z7) in the DCT+RLE EEG compression path.
- Accepts the 18-bit signed DCT coefficients of one 8-point block, serialized in index order.
- Quantizes each coefficient, run-length encodes the zero runs, and emits (run, level) symbols followed by an end-of-block (EOB) symbol.
- Uses a valid/ready handshake on both sides, so it can sit between the DCT serializer and the bitstream packer.

Parameters:
COEF_W, 18, input coefficient width (two's complement)
LEVEL_W, 8, output level width (two's complement)
BLOCK_LEN, 8, coefficients per block
RUN_W, 3, run field width, equal to clog2(BLOCK_LEN)
QSHIFT, 4, quantizer right-shift amount

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 asserts)
in_valid  in  1  in_coef/in_last valid
in_ready  out  1  block can accept a coefficient this cycle
in_coef  in  COEF_W  DCT coefficient, signed
in_last  in  1  marks the last coefficient of the block
out_valid  out  1  output symbol valid
out_ready  in  1  consumer accepts the symbol
out_run  out  RUN_W  number of zero coefficients preceding level
out_level  out  LEVEL_W  quantized nonzero level, signed; 0 on EOB
out_eob  out  1  symbol is an end-of-block marker
err_len  out  1  one-cycle pulse on a block-length mismatch

Behaviour:
- Reset (async assert, sync deassert by the source):
  - out_valid, out_run, out_level, out_eob and err_len are 0.
  - Index counter, run counter and FSM clear. FSM goes to S_ACCEPT.
  - in_ready = 0 while reset is asserted.
- Reset mid-block: the partial block, pending EOB and held symbol are discarded. No EOB is emitted.
- Input accept: in_valid && in_ready. Output accept: out_valid && out_ready.
- Quantizer (combinational):
  - q = trunc-toward-zero(in_coef / 2^QSHIFT). Negative inputs add 2^QSHIFT-1 before the arithmetic shift.
  - q saturates to [-(2^(LEVEL_W-1)-1), +(2^(LEVEL_W-1)-1)], i.e. ±127. -128 is never produced.
- FSM states:
  - S_ACCEPT: in_ready = !out_valid || out_ready.
  - S_EOB: in_ready = 0.
- Block close occurs when the accepted coefficient has in_last=1 or index==BLOCK_LEN-1, whichever comes first.
- err_len pulses for 1 cycle, registered with the closing symbol, when these two disagree: in_last early, or index==BLOCK_LEN-1 without in_last.
- Per accepted coefficient in S_ACCEPT (output register loads on the next edge, so latency is 1 cycle):
  - q != 0: emit (run_cnt, q, eob=0); run_cnt <= 0.
  - q == 0, not close: run_cnt++, no symbol.
  - q == 0, close: emit EOB (run=0, level=0, eob=1). Trailing zeros are dropped.
  - q != 0, close: emit (run_cnt, q). FSM goes to S_EOB. EOB is loaded when that symbol is accepted, then FSM returns to S_ACCEPT.
- On block close, index and run_cnt return to 0.
- Output hold: while out_valid && !out_ready, all out_* stay stable and no input is accepted.
- Simultaneous output accept and new input accept in the same cycle is legal: the output register reloads with no bubble. Throughput is 1 coefficient/cycle except for one extra cycle when a block ends with a nonzero coefficient.
- run_cnt never exceeds BLOCK_LEN-1, so no overflow handling is required.

Decomposition:
- rle_pkg holds:
  - COEF_W, LEVEL_W, BLOCK_LEN, RUN_W and QSHIFT defaults
  - the state enum {S_ACCEPT, S_EOB}
  - LEVEL_MAX/LEVEL_MIN saturation constants
  - the EOB symbol constant
- One sub-module: coef_quant, the combinational truncate+saturate quantizer, parameterised by COEF_W, LEVEL_W and QSHIFT.
- Counters, FSM and output register live in rle_encoder.

Test Plan:
1. Block of 8 zeros, in_last on index 7, out_ready=1 -> exactly one symbol (run=0, level=0, eob=1) one cycle after the 8th accept; err_len=0.
2. Block [160,0,0,-48,0,0,0,0] -> symbols (0,10), (2,-3), then EOB. -1 and 15 in other slots quantize to 0 and extend runs.
3. Block [0,0,0,0,0,0,0,32] -> (7,2) then EOB. in_ready=0 for the cycle EOB is pending; the next block's first coefficient is accepted right after.
4. Saturation: in_coef=131071 -> level 127; in_coef=-131072 -> level -127. Never -128.
5. Backpressure: out_ready=0 for 3 cycles mid-block -> out_* stable, in_ready=0, no symbol lost or duplicated. Sequence equals the out_ready=1 case.
6. in_last on index 4 -> block closes, EOB emitted, err_len pulses once, next block restarts at index 0. Assert reset (reset=0) mid-block -> all outputs 0 immediately; after release the next block encodes cleanly.
